l2_arbiter: RTL and testbench
=============================

# l2_arbiter

Two-requester arbiter that shares the single L1-facing port of the unified L2 cache between the L1 instruction cache (read-only) and the L1 data cache (read/write). It sits between both L1 caches and the L2 cache controller/datapath. It grants one 256-bit line transaction at a time and holds the grant until the L2 responds. It then steers the response and read data back to the granted L1 only.

## Interface
- Parameters:
- `s_line`, 256, cache line width in bits
- `s_mask`, 32, byte-enable width (`s_line/8`)
- Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `icache_address`  in  32  I-side line address
- `icache_read`  in  1  I-side read request, held until `icache_resp`
- `icache_rdata`  out  256  I-side read data
- `icache_resp`  out  1  I-side completion pulse
- `dcache_address`  in  32  D-side line address
- `dcache_read`  in  1  D-side read request, held until `dcache_resp`
- `dcache_write`  in  1  D-side write request, held until `dcache_resp`
- `dcache_byte_enable256`  in  32  D-side write byte enables
- `dcache_wdata`  in  256  D-side write data
- `dcache_rdata`  out  256  D-side read data
- `dcache_resp`  out  1  D-side completion pulse
- `l2_address`  out  32  to L2 `mem_address`
- `l2_byte_enable256`  out  32  to L2 `mem_byte_enable256`
- `l2_read`, `l2_write`  out  1  to L2 `L1_read` / `L1_write`
- `l2_wdata`  out  256  to L2 `L1_wdata`
- `l2_rdata`  in  256  from L2 `L1_rdata`
- `l2_resp`  in  1  from L2 `L1_resp`

## Operation
- The FSM has three states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - All `l2_*` outputs are 0.
  - If any request is pending, the arbiter picks a winner and moves to SERVE_I or SERVE_D on the next edge.
  - `l2_resp` received in IDLE is ignored.
- SERVE_I:
  - `l2_address` = `icache_address`, `l2_read` = 1, `l2_write` = 0, `l2_byte_enable256` = 0, `l2_wdata` = 0.
  - On `l2_resp`, `icache_resp` = 1 in the same cycle and the FSM returns to IDLE.
- SERVE_D:
  - `l2_address`, byte enables and wdata are driven from the dcache inputs.
  - `l2_read` = `dcache_read & ~dcache_write` and `l2_write` = `dcache_write`. Write wins if both are asserted.
  - On `l2_resp`, `dcache_resp` = 1 in the same cycle and the FSM returns to IDLE.
- Forwarding to L2 is combinational from the granted requester's inputs. The requester must hold its inputs stable until its resp.
- `icache_rdata` and `dcache_rdata` both mirror `l2_rdata`. Only the granted side's resp qualifies the data.
- A resp never goes to the non-granted side.
- A request that is dropped while granted is protocol misuse. The FSM stays in SERVE_x until `l2_resp`.

## Timing
- Reset values:
  - State is IDLE.
  - All resp, `l2_read` and `l2_write` are 0.
  - The priority register is set to prefer D.
- Grant latency:
  - A request seen in IDLE at cycle N gives `l2_read`/`l2_write` asserted in cycle N+1.
  - Total latency is 1 cycle plus the L2 latency.
- Every transaction ends with one mandatory IDLE cycle. This lets the L1 deassert its request after its resp and prevents a stale re-grant.
- With back-to-back pending requests, transactions start at most every L2 latency + 1 cycles.
- Simultaneous I and D requests in IDLE are resolved per Configuration.
- `rst` asserted mid-transaction:
  - State goes to IDLE on that edge and all outputs are 0 the next cycle.
  - The in-flight transaction is abandoned with no resp.
  - The L2 is reset with the same `rst`.

## Configuration
- `L2_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit priority register records the side served last. On contention the other side wins.
  - The register updates on each grant, i.e. on IDLE→SERVE transitions.
  - Neither side waits more than one foreign transaction.
- Not defined:
  - Fixed priority, D over I.
  - There is no priority register, and the I side can starve under continuous D traffic.

## Structure
- Package `l2_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, SERVE_I, SERVE_D}
  - `requester_t` enum {REQ_I, REQ_D}
  - localparams for line width and byte-enable width
- One natural sub-module, `l2_arb_select`:
  - Combinational winner selection from (`icache_read`, `dcache_read|dcache_write`, priority bit), returning `requester_t` plus a valid flag.
- The FSM, priority register and output muxing live in `l2_arbiter`.

## Test plan
- I-only read:
  - Stimulus: `icache_address`=0x0000_1000; L2 responds 3 cycles after `l2_read`, with rdata=0xAA..AA.
  - Required: `l2_read` rises 1 cycle after the request, `icache_resp` pulses once with rdata 0xAA..AA, and `dcache_resp` stays 0.
- D write:
  - Stimulus: `dcache_address`=0x0000_2020, byte enable 0x0000_000F, wdata 0x11..11.
  - Required: `l2_write`=1 with matching address, byte enable and data, `l2_read`=0; `dcache_resp` coincides with `l2_resp`.
- Simultaneous I read and D read in IDLE:
  - Required: D is served first in both builds.
  - With `L2_ARB_ROUND_ROBIN_EN`, repeated contention alternates I, D, I, …
  - Without it, D is always served while D is asserted.
- Back-to-back D requests:
  - Required: exactly one IDLE cycle with `l2_read`/`l2_write`=0 between consecutive transactions.
- Spurious `l2_resp` in IDLE:
  - Required: no resp is asserted to either L1 and the state stays IDLE.
- `rst` asserted 2 cycles into a SERVE_I transaction:
  - Required: the next cycle shows state IDLE and all outputs 0; a later I request is re-granted normally.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types and widths for the two-requester L2 port arbiter.
// The optional round-robin build is selected by L2_ARB_ROUND_ROBIN_EN (see l2_arbiter).
package l2_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned MASK_W = LINE_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

endpackage

// File: rtl/l2_arb_select.sv
// Combinational winner selection between the I and D requesters.
// On contention the side that was not served last wins.
module l2_arb_select
  import l2_arb_pkg::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  requester_t last_i,
  output requester_t winner_o,
  output logic       valid_o
);

  assign valid_o = i_req_i | d_req_i;

  // NOTE: assign a default first so no branch can leave winner_o unassigned and infer a latch.
  always_comb begin
    winner_o = REQ_D;
    if (i_req_i && !d_req_i) begin
      winner_o = REQ_I;
    end else if (i_req_i && d_req_i) begin
      winner_o = (last_i == REQ_D) ? REQ_I : REQ_D;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the L2 cache's L1-facing port between the L1 I-cache and D-cache.
// Define L2_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed D-over-I priority.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned s_line = LINE_W,
  parameter int unsigned s_mask = MASK_W
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [ADDR_W-1:0]   icache_address,
  input  logic                icache_read,
  output logic [s_line-1:0]   icache_rdata,
  output logic                icache_resp,

  input  logic [ADDR_W-1:0]   dcache_address,
  input  logic                dcache_read,
  input  logic                dcache_write,
  input  logic [s_mask-1:0]   dcache_byte_enable256,
  input  logic [s_line-1:0]   dcache_wdata,
  output logic [s_line-1:0]   dcache_rdata,
  output logic                dcache_resp,

  output logic [ADDR_W-1:0]   l2_address,
  output logic [s_mask-1:0]   l2_byte_enable256,
  output logic                l2_read,
  output logic                l2_write,
  output logic [s_line-1:0]   l2_wdata,
  input  logic [s_line-1:0]   l2_rdata,
  input  logic                l2_resp
);

  arb_state_t state_q;
  requester_t last_q;
  requester_t sel_winner;
  logic       sel_valid;

  l2_arb_select u_select (
    .i_req_i  (icache_read),
    .d_req_i  (dcache_read | dcache_write),
    .last_i   (last_q),
    .winner_o (sel_winner),
    .valid_o  (sel_valid)
  );

`ifdef L2_ARB_ROUND_ROBIN_EN
  // Records the side granted last; reset value makes D win the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_I;
    end else if (state_q == IDLE && sel_valid) begin
      last_q <= sel_winner;
    end
  end
`else
  // Tying "last served" to I makes the selector a fixed D-over-I priority.
  assign last_q = REQ_I;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            state_q <= (sel_winner == REQ_D) ? SERVE_D : SERVE_I;
          end
        end
        SERVE_I: if (l2_resp) state_q <= IDLE;
        SERVE_D: if (l2_resp) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is broadcast; only the granted side's resp qualifies it.
  assign icache_rdata = l2_rdata;
  assign dcache_rdata = l2_rdata;

  always_comb begin
    l2_address        = '0;
    l2_byte_enable256 = '0;
    l2_read           = 1'b0;
    l2_write          = 1'b0;
    l2_wdata          = '0;
    icache_resp       = 1'b0;
    dcache_resp       = 1'b0;
    case (state_q)
      SERVE_I: begin
        l2_address  = icache_address;
        l2_read     = 1'b1;
        icache_resp = l2_resp;
      end
      SERVE_D: begin
        l2_address        = dcache_address;
        l2_byte_enable256 = dcache_byte_enable256;
        l2_wdata          = dcache_wdata;
        l2_read           = dcache_read & ~dcache_write;
        l2_write          = dcache_write;
        dcache_resp       = l2_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed self-checking bench for l2_arbiter; expectations adapt to L2_ARB_ROUND_ROBIN_EN.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
module tb_l2_arbiter;
  import l2_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  icache_address;
  logic         icache_read;
  logic [255:0] icache_rdata;
  logic         icache_resp;
  logic [31:0]  dcache_address;
  logic         dcache_read;
  logic         dcache_write;
  logic [31:0]  dcache_byte_enable256;
  logic [255:0] dcache_wdata;
  logic [255:0] dcache_rdata;
  logic         dcache_resp;
  logic [31:0]  l2_address;
  logic [31:0]  l2_byte_enable256;
  logic         l2_read;
  logic         l2_write;
  logic [255:0] l2_wdata;
  logic [255:0] l2_rdata;
  logic         l2_resp;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  l2_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .icache_address        (icache_address),
    .icache_read           (icache_read),
    .icache_rdata          (icache_rdata),
    .icache_resp           (icache_resp),
    .dcache_address        (dcache_address),
    .dcache_read           (dcache_read),
    .dcache_write          (dcache_write),
    .dcache_byte_enable256 (dcache_byte_enable256),
    .dcache_wdata          (dcache_wdata),
    .dcache_rdata          (dcache_rdata),
    .dcache_resp           (dcache_resp),
    .l2_address            (l2_address),
    .l2_byte_enable256     (l2_byte_enable256),
    .l2_read               (l2_read),
    .l2_write              (l2_write),
    .l2_wdata              (l2_wdata),
    .l2_rdata              (l2_rdata),
    .l2_resp               (l2_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    icache_address        = '0;
    icache_read           = 1'b0;
    dcache_address        = '0;
    dcache_read           = 1'b0;
    dcache_write          = 1'b0;
    dcache_byte_enable256 = '0;
    dcache_wdata          = '0;
    l2_rdata              = '0;
    l2_resp               = 1'b0;
  endtask

  // Entry: requests already driven, arbiter in IDLE this cycle. Exit: first cycle after the resp edge.
  task automatic run_txn(input string name, input bit exp_d, input bit exp_wr,
                         input logic [31:0] exp_addr, input logic [31:0] exp_be,
                         input logic [255:0] exp_wd, input int lat, input logic [255:0] rd);
    logic [1:0]   exp_resp;
    logic [255:0] got_rd;
    exp_resp = exp_d ? 2'b01 : 2'b10;
    @(negedge clk);
    total_cnt++;
    if ({l2_read, l2_write, icache_resp, dcache_resp} !== 4'b0000)
      $display("FAIL %s idle_cycle: rd/wr/iresp/dresp=%b expected 0000", name,
               {l2_read, l2_write, icache_resp, dcache_resp});
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if ({l2_read, l2_write, l2_address} !== {~exp_wr, exp_wr, exp_addr})
      $display("FAIL %s grant: rd=%b wr=%b addr=%h expected rd=%b wr=%b addr=%h", name,
               l2_read, l2_write, l2_address, ~exp_wr, exp_wr, exp_addr);
    else pass_cnt++;
    total_cnt++;
    if ({l2_byte_enable256, l2_wdata} !== {exp_be, exp_wd})
      $display("FAIL %s fwd_data: be=%h wdata=%h expected be=%h wdata=%h", name,
               l2_byte_enable256, l2_wdata, exp_be, exp_wd);
    else pass_cnt++;
    for (int k = 1; k < lat; k++) begin
      tick();
      @(negedge clk);
      total_cnt++;
      if ({icache_resp, dcache_resp} !== 2'b00)
        $display("FAIL %s early_resp: iresp/dresp=%b expected 00", name, {icache_resp, dcache_resp});
      else pass_cnt++;
    end
    tick();
    l2_resp  = 1'b1;
    l2_rdata = rd;
    @(negedge clk);
    got_rd = exp_d ? dcache_rdata : icache_rdata;
    total_cnt++;
    if ({icache_resp, dcache_resp} !== exp_resp || got_rd !== rd)
      $display("FAIL %s resp: iresp/dresp=%b rdata=%h expected %b rdata=%h", name,
               {icache_resp, dcache_resp}, got_rd, exp_resp, rd);
    else pass_cnt++;
    tick();
    l2_resp  = 1'b0;
    l2_rdata = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    total_cnt++;
    if (dut.state_q !== IDLE ||
        {l2_read, l2_write, icache_resp, dcache_resp, l2_address} !== 36'h0)
      $display("FAIL reset: state=%0d rd=%b wr=%b iresp=%b dresp=%b addr=%h expected IDLE and zeros",
               dut.state_q, l2_read, l2_write, icache_resp, dcache_resp, l2_address);
    else pass_cnt++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_i_read();
    icache_address = 32'h0000_1000;
    icache_read    = 1'b1;
    run_txn("i_read", 1'b0, 1'b0, 32'h0000_1000, 32'h0, '0, 3, {32{8'hAA}});
    icache_read = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (dut.state_q !== IDLE || {icache_resp, dcache_resp, l2_read} !== 3'b000)
      $display("FAIL i_read_after: state=%0d iresp=%b dresp=%b rd=%b expected IDLE 0 0 0",
               dut.state_q, icache_resp, dcache_resp, l2_read);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_d_write();
    dcache_address        = 32'h0000_2020;
    dcache_byte_enable256 = 32'h0000_000F;
    dcache_wdata          = {64{4'h1}};
    dcache_write          = 1'b1;
    run_txn("d_write", 1'b1, 1'b1, 32'h0000_2020, 32'h0000_000F, {64{4'h1}}, 2, '0);
    // Read and write together: write must win.
    dcache_read = 1'b1;
    run_txn("d_write_wins", 1'b1, 1'b1, 32'h0000_2020, 32'h0000_000F, {64{4'h1}}, 1, '0);
    clear_inputs();
    tick();
  endtask

  task automatic test_contention();
    bit exp_d [3];
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef L2_ARB_ROUND_ROBIN_EN
    exp_d = '{1'b1, 1'b0, 1'b1};
`else
    exp_d = '{1'b1, 1'b1, 1'b1};
`endif
    icache_address = 32'h0000_1000;
    icache_read    = 1'b1;
    dcache_address = 32'h0000_3000;
    dcache_read    = 1'b1;
    for (int t = 0; t < 3; t++) begin
      run_txn($sformatf("contention%0d", t), exp_d[t], 1'b0,
              exp_d[t] ? 32'h0000_3000 : 32'h0000_1000, 32'h0, '0, 2,
              {8{t[3:0] + 4'h5, 28'h0ABCDEF}});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    dcache_address = 32'h0000_5540;
    dcache_read    = 1'b1;
    run_txn("b2b_0", 1'b1, 1'b0, 32'h0000_5540, 32'h0, '0, 1, {16{16'hC3C3}});
    dcache_address = 32'h0000_5560;
    run_txn("b2b_1", 1'b1, 1'b0, 32'h0000_5560, 32'h0, '0, 1, {16{16'h3C3C}});
    clear_inputs();
    tick();
  endtask

  task automatic test_spurious_resp();
    l2_resp  = 1'b1;
    l2_rdata = {32{8'h5A}};
    @(negedge clk);
    total_cnt++;
    if ({icache_resp, dcache_resp, l2_read, l2_write} !== 4'b0000)
      $display("FAIL spurious_resp: iresp/dresp/rd/wr=%b expected 0000",
               {icache_resp, dcache_resp, l2_read, l2_write});
    else pass_cnt++;
    tick();
    l2_resp = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (dut.state_q !== IDLE)
      $display("FAIL spurious_state: state=%0d expected IDLE", dut.state_q);
    else pass_cnt++;
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_txn();
    icache_address = 32'h0000_4000;
    icache_read    = 1'b1;
    tick();
    tick();
    @(negedge clk);
    total_cnt++;
    if ({l2_read, icache_resp} !== 2'b10)
      $display("FAIL mid_serving: rd=%b iresp=%b expected 1 0", l2_read, icache_resp);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    icache_read = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (dut.state_q !== IDLE ||
        {l2_read, l2_write, icache_resp, dcache_resp} !== 4'b0000 ||
        l2_address !== 32'h0 || l2_byte_enable256 !== 32'h0 || l2_wdata !== '0 ||
        icache_rdata !== '0 || dcache_rdata !== '0)
      $display("FAIL mid_reset: state=%0d rd=%b wr=%b iresp=%b dresp=%b addr=%h expected IDLE and zeros",
               dut.state_q, l2_read, l2_write, icache_resp, dcache_resp, l2_address);
    else pass_cnt++;
    tick();
    icache_address = 32'h0000_4000;
    icache_read    = 1'b1;
    run_txn("regrant", 1'b0, 1'b0, 32'h0000_4000, 32'h0, '0, 2, {32{8'h96}});
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_back_to_back();
    test_spurious_resp();
    test_reset_mid_txn();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
